pifo_enqueue_ctrl: RTL and testbench
====================================

Name: pifo_enqueue_ctrl

Overview:
- Admission and tagging stage directly upstream of the output queue (`output_queue_v0_1_with_cpu`).
- Takes a 256-bit AXI-Stream packet and a per-packet rank, and makes a whole-packet admit/drop decision at the head beat using the queue's almost-full flag.
- Forwards admitted packets through one registered stage, driving `buffer_wr_en` on every beat, `pifo_insert_en` on the head beat only, and a 32-bit PIFO descriptor on every beat.
- Keeps 32-bit admitted and dropped packet counters.

Parameters:
- DATA_WIDTH, 256, stream data width
- KEEP_WIDTH, 32, DATA_WIDTH/8
- USER_WIDTH, 128, tuser width
- RANK_IN_WIDTH, 32, width of the incoming rank sideband
- RANK_WIDTH, 19, rank field width in the descriptor

Ports:
- axis_aclk  in  1  clock
- axis_resetn  in  1  reset
- s_axis_tdata  in  DATA_WIDTH  packet data
- s_axis_tkeep  in  KEEP_WIDTH  byte enables
- s_axis_tuser  in  USER_WIDTH  metadata
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat
- s_axis_trank  in  RANK_IN_WIDTH  rank; sampled on head beat only
- s_axis_tready  out  1  beat accepted when valid&&ready
- m_axis_tdata/tkeep/tuser/tlast  out  as input  registered copies
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  queue accepts beat
- m_axis_tpifo  out  32  {valid=1, rank[18:0], 12'b0}
- m_axis_buffer_wr_en  out  1  equals m_axis_tvalid
- m_axis_pifo_insert_en  out  1  high on head beat of admitted packet only
- m_is_buffer_almost_full  in  1  from output queue
- admitted_count  out  32  packets admitted, saturating
- dropped_count  out  32  packets dropped, saturating

Behaviour:
- **Reset.** One clock; reset is synchronous and active-low (`axis_resetn` sampled on the rising edge of `axis_aclk`). While reset is asserted:
  - all m_* outputs and both counters are 0;
  - state is IDLE;
  - s_axis_tready is 0.
- **Reset mid-packet.** The rest of an interrupted packet is not recovered. The first beat accepted after reset is treated as a head.
- **Handshake.**
  - s_axis_tready = !out_valid || m_axis_tready, also during DROP, so dropped beats are consumed at the same rate.
  - The output register loads on accept when in admit mode.
  - out_valid clears when m_axis_tready is high and no new beat loads.
  - Latency is 1 cycle from input accept to m_axis_tvalid.
  - Output is held stable while m_axis_tvalid && !m_axis_tready.
- **States.**
  - IDLE: on accepted beat (the head):
    - admit if m_is_buffer_almost_full==0 in that cycle; else drop;
    - admit: latch descriptor, emit beat with pifo_insert_en=1, go to FWD;
    - drop: emit nothing, go to DROP;
    - if tlast is set on the head beat, stay in IDLE and count the packet that cycle.
  - FWD: forward each accepted beat with pifo_insert_en=0 and the latched descriptor. On accepted tlast: admitted_count++ and go to IDLE.
  - DROP: discard accepted beats. On accepted tlast: dropped_count++ and go to IDLE.
- **Decision timing.** The admit/drop decision is fixed at the head beat. Almost-full changing mid-packet has no effect on that packet.
- **Rank.** rank = min(s_axis_trank, 2^RANK_WIDTH-1), i.e. values ≥0x80000 clamp to 0x7FFFF. Descriptor = {1'b1, rank, 12'h000}.
- **Counters.** Saturate at 0xFFFFFFFF. A single-beat packet increments its counter exactly once.
- **Idle gaps.** s_axis_tvalid low mid-packet holds state; no output beat is generated.

Decomposition:
- **Shared package `pifo_pkg`:**
  - descriptor field constants: PIFO_VALID_BIT=31, RANK_LSB=12, RANK_WIDTH=19, RSVD_WIDTH=12;
  - state enum {IDLE, FWD, DROP};
  - function `make_pifo_desc(rank)`.
- **Sub-module `axis_reg_slice`:** one-stage output register with the valid/ready rule above. The FSM, clamp and counters stay in the top level.

Test Plan:
- **Admit, always ready.** 3-beat pkt 1a,1b,1c, rank=100, almost_full=0, m_axis_tready=1 → beats out 1 cycle later:
  - tpifo=0x80064000 on all beats;
  - pifo_insert_en only on 1a;
  - buffer_wr_en on all 3;
  - admitted_count=1.
- **Backpressure mid-packet.** 6-beat pkt 2a..2f, m_axis_tready drops after 2c for 3 cycles → 2d held stable on outputs, s_axis_tready=0; all 6 beats delivered in order, none duplicated.
- **Drop on almost-full.** almost_full=1 on head 3a, then 0 for 3b..3f → no m_axis_tvalid for the whole packet, s_axis_tready=1 throughout, dropped_count=1.
- **Back-to-back and late almost-full.** Pkt 4 (rank 50) then pkt 5 (rank 10); almost_full rises during pkt 4's 2nd beat → pkt 4 fully forwarded with tpifo=0x80032000; pkt 5 dropped; counts admitted=1, dropped=1.
- **Rank clamp and single beat.** rank=0x00100000, tlast on head → tpifo=0xFFFFF000, pifo_insert_en=1 with tlast=1, FSM back in IDLE next cycle.
- **Reset mid-packet.** axis_resetn=0 for 2 cycles during FWD beat 2 of 4 → outputs and counters 0. The next accepted beat is treated as a head and gets pifo_insert_en=1.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO enqueue path: descriptor layout, FSM states, descriptor builder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pifo_pkg;

    localparam int PIFO_VALID_BIT = 31;
    localparam int RANK_LSB       = 12;
    localparam int RANK_WIDTH     = 19;
    localparam int RSVD_WIDTH     = 12;
    localparam int DESC_WIDTH     = 1 + RANK_WIDTH + RSVD_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    // Descriptor = {valid, rank, reserved zeros}; the rank must already be clamped.
    function automatic logic [DESC_WIDTH-1:0] make_pifo_desc(input logic [RANK_WIDTH-1:0] rank);
        logic [DESC_WIDTH-1:0] desc;
        desc                         = '0;
        desc[PIFO_VALID_BIT]         = 1'b1;
        desc[RANK_LSB +: RANK_WIDTH] = rank;
        return desc;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage registered output slice for a valid/ready stream.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: out_dat held while out_vld && !out_rdy; caller only loads when !out_vld || out_rdy.
//
// Ports: clk/rst_n (sync active-low), in_vld/in_dat load strobe and payload,
//        out_vld/out_dat registered beat, out_rdy downstream accept.
module axis_reg_slice #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            // Data is left in place once consumed; only the valid flag drops.
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/pifo_enqueue_ctrl.sv
// Whole-packet admit/drop at the head beat, PIFO descriptor tagging, admitted/dropped counters.
// Latency: 1 cycle from input accept to m_axis_tvalid.
// Backpressure: s_axis_tready = !out_valid || m_axis_tready in every state, so dropped beats drain at line rate.
//
// Ports: s_axis_* packet input with head-beat rank sideband; m_axis_* registered output with
//        buffer_wr_en, pifo_insert_en and tpifo descriptor; m_is_buffer_almost_full admission input;
//        admitted_count/dropped_count saturating packet counters.
module pifo_enqueue_ctrl #(
    parameter int DATA_WIDTH    = 256,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 128,
    parameter int RANK_IN_WIDTH = 32,
    parameter int RANK_WIDTH    = 19
) (
    input  logic                     axis_aclk,
    input  logic                     axis_resetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    input  logic [RANK_IN_WIDTH-1:0] s_axis_trank,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [31:0]              m_axis_tpifo,
    output logic                     m_axis_buffer_wr_en,
    output logic                     m_axis_pifo_insert_en,
    input  logic                     m_is_buffer_almost_full,
    output logic [31:0]              admitted_count,
    output logic [31:0]              dropped_count
);

    import pifo_pkg::*;

    localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1 + DESC_WIDTH + 1;
    localparam logic [RANK_IN_WIDTH-1:0] RANK_MAX =
        RANK_IN_WIDTH'((64'd1 << RANK_WIDTH) - 64'd1);

    state_t                  state_q;
    state_t                  state_d;
    logic [DESC_WIDTH-1:0]   desc_q;
    logic [DESC_WIDTH-1:0]   head_desc;
    logic [DESC_WIDTH-1:0]   beat_desc;
    logic [RANK_WIDTH-1:0]   rank_clamped;
    logic                    in_acc;
    logic                    is_head;
    logic                    admit_beat;
    logic                    done_adm;
    logic                    done_drp;
    logic                    out_vld;
    logic                    out_ins;
    logic [PAY_W-1:0]        pay_in;
    logic [PAY_W-1:0]        pay_out;

    // Reset gates ready so nothing is accepted while the pipeline is being cleared.
    assign s_axis_tready = axis_resetn && (!out_vld || m_axis_tready);
    assign in_acc        = s_axis_tvalid && s_axis_tready;

    assign rank_clamped = (s_axis_trank > RANK_MAX) ? RANK_MAX[RANK_WIDTH-1:0]
                                                    : s_axis_trank[RANK_WIDTH-1:0];
    assign head_desc    = make_pifo_desc(rank_clamped);
    // Head beat carries its freshly built descriptor; body beats reuse the latched one.
    assign beat_desc    = is_head ? head_desc : desc_q;

    always_comb begin
        state_d    = state_q;
        is_head    = 1'b0;
        admit_beat = 1'b0;
        done_adm   = 1'b0;
        done_drp   = 1'b0;
        unique case (state_q)
            IDLE: begin
                is_head = 1'b1;
                if (in_acc) begin
                    if (!m_is_buffer_almost_full) begin
                        admit_beat = 1'b1;
                        if (s_axis_tlast) done_adm = 1'b1;
                        else              state_d  = FWD;
                    end else begin
                        if (s_axis_tlast) done_drp = 1'b1;
                        else              state_d  = DROP;
                    end
                end
            end
            FWD: begin
                if (in_acc) begin
                    admit_beat = 1'b1;
                    if (s_axis_tlast) begin
                        done_adm = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            DROP: begin
                if (in_acc && s_axis_tlast) begin
                    done_drp = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q        <= IDLE;
            desc_q         <= '0;
            admitted_count <= '0;
            dropped_count  <= '0;
        end else begin
            state_q <= state_d;
            if (admit_beat && is_head) desc_q <= head_desc;
            if (done_adm && (admitted_count != 32'hFFFF_FFFF)) admitted_count <= admitted_count + 32'd1;
            if (done_drp && (dropped_count  != 32'hFFFF_FFFF)) dropped_count  <= dropped_count  + 32'd1;
        end
    end

    assign pay_in = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, beat_desc, is_head};

    // admit_beat implies in_acc, which implies the slice is free to load.
    axis_reg_slice #(.W(PAY_W)) u_out_slice (
        .clk     (axis_aclk),
        .rst_n   (axis_resetn),
        .in_vld  (admit_beat),
        .in_dat  (pay_in),
        .out_rdy (m_axis_tready),
        .out_vld (out_vld),
        .out_dat (pay_out)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tpifo, out_ins} = pay_out;
    assign m_axis_tvalid         = out_vld;
    assign m_axis_buffer_wr_en   = out_vld;
    assign m_axis_pifo_insert_en = out_vld && out_ins;

endmodule

// File: tb/tb_pifo_enqueue_ctrl.sv
module tb_pifo_enqueue_ctrl;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tlast;
    logic [31:0]   s_trank;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [31:0]   m_tpifo;
    logic          m_wr_en;
    logic          m_ins;
    logic          af;
    logic [31:0]   adm_cnt;
    logic [31:0]   drp_cnt;

    always #5 clk = ~clk;

    pifo_enqueue_ctrl dut (
        .axis_aclk               (clk),
        .axis_resetn             (resetn),
        .s_axis_tdata            (s_tdata),
        .s_axis_tkeep            (s_tkeep),
        .s_axis_tuser            (s_tuser),
        .s_axis_tvalid           (s_tvalid),
        .s_axis_tlast            (s_tlast),
        .s_axis_trank            (s_trank),
        .s_axis_tready           (s_tready),
        .m_axis_tdata            (m_tdata),
        .m_axis_tkeep            (m_tkeep),
        .m_axis_tuser            (m_tuser),
        .m_axis_tlast            (m_tlast),
        .m_axis_tvalid           (m_tvalid),
        .m_axis_tready           (m_tready),
        .m_axis_tpifo            (m_tpifo),
        .m_axis_buffer_wr_en     (m_wr_en),
        .m_axis_pifo_insert_en   (m_ins),
        .m_is_buffer_almost_full (af),
        .admitted_count          (adm_cnt),
        .dropped_count           (drp_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired, required event never occurred", name);
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        logic [31:0]   p;
        logic          ins;
    } beat_t;

    beat_t       exp_q[$];
    logic        mdl_head     = 1'b1;
    logic        mdl_admit    = 1'b0;
    logic [31:0] mdl_desc     = '0;
    logic [31:0] mdl_adm      = '0;
    logic [31:0] mdl_drp      = '0;
    int          out_beats    = 0;
    logic [31:0] last_head_p  = '0;
    logic        last_head_l  = 1'b0;
    logic        rst_prev_low = 1'b0;
    logic        held_v       = 1'b0;
    beat_t       held;

    always @(negedge clk) begin
        beat_t b;
        logic [31:0] r;
        if (!resetn) begin
            chk("rst_s_tready", s_tready, 1'b0);
            if (rst_prev_low) begin
                chk("rst_m_tvalid", m_tvalid, 1'b0);
                chk("rst_wr_en",    m_wr_en,  1'b0);
                chk("rst_insert",   m_ins,    1'b0);
                chk("rst_tpifo",    m_tpifo,  32'h0);
                chk("rst_tdata",    m_tdata,  256'h0);
                chk("rst_adm_cnt",  adm_cnt,  32'h0);
                chk("rst_drp_cnt",  drp_cnt,  32'h0);
            end
            exp_q.delete();
            mdl_head     = 1'b1;
            mdl_adm      = '0;
            mdl_drp      = '0;
            held_v       = 1'b0;
            rst_prev_low = 1'b1;
        end else begin
            rst_prev_low = 1'b0;
            chk("tready_rule", s_tready, (!m_tvalid) || m_tready);
            chk("wr_en_eq_valid", m_wr_en, m_tvalid);
            chk("adm_cnt", adm_cnt, mdl_adm);
            chk("drp_cnt", drp_cnt, mdl_drp);
            if (held_v) begin
                chk("hold_valid", m_tvalid, 1'b1);
                chk("hold_tdata", m_tdata, held.d);
                chk("hold_tuser", m_tuser, held.u);
                chk("hold_ctl", {m_tkeep, m_tlast, m_tpifo, m_ins}, {held.k, held.l, held.p, held.ins});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    fail_to("unexpected_output_beat");
                end else begin
                    b = exp_q.pop_front();
                    chk("out_tdata",  m_tdata, b.d);
                    chk("out_tuser",  m_tuser, b.u);
                    chk("out_keep_last", {m_tkeep, m_tlast}, {b.k, b.l});
                    chk("out_tpifo",  m_tpifo, b.p);
                    chk("out_insert", m_ins,   b.ins);
                end
                out_beats++;
                if (m_ins) begin
                    last_head_p = m_tpifo;
                    last_head_l = m_tlast;
                end
            end
            held_v = m_tvalid && !m_tready;
            held   = '{d: m_tdata, k: m_tkeep, u: m_tuser, l: m_tlast, p: m_tpifo, ins: m_ins};
            if (s_tvalid && s_tready) begin
                if (mdl_head) begin
                    mdl_admit = !af;
                    r         = (s_trank > 32'h0007_FFFF) ? 32'h0007_FFFF : s_trank;
                    mdl_desc  = 32'h8000_0000 | (r << 12);
                end
                if (mdl_admit)
                    exp_q.push_back('{d: s_tdata, k: s_tkeep, u: s_tuser, l: s_tlast, p: mdl_desc, ins: mdl_head});
                if (s_tlast) begin
                    if (mdl_admit) mdl_adm = mdl_adm + 1;
                    else           mdl_drp = mdl_drp + 1;
                    mdl_head = 1'b1;
                end else begin
                    mdl_head = 1'b0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic rnd_rdy = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rnd_rdy) begin
                #1;
                m_tready = ($urandom_range(99) < 65);
            end
        end
    end

    // af_rest: 0/1 fixed level for body beats, 2 = random per beat.
    task automatic send_pkt(input int n, input logic [31:0] rank, input bit af_head,
                            input int af_rest, input int gap_pct, input int stop_after);
        bit ok;
        for (int b = 0; b < n && b < stop_after; b++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            for (int w = 0; w < DW / 32; w++) s_tdata[w*32 +: 32] = $urandom;
            for (int w = 0; w < UW / 32; w++) s_tuser[w*32 +: 32] = $urandom;
            s_tkeep = $urandom;
            s_tlast = (b == n - 1);
            s_trank = (b == 0) ? rank : $urandom;
            if (b == 0)          af = af_head;
            else if (af_rest==2) af = $urandom_range(1);
            else                 af = (af_rest != 0);
            ok = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (s_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!ok) begin
                fail_to("input_accept");
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_tvalid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_to("drain");
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          n;
        logic [31:0] rank;
        bit          af_head;
        int          af_rest;
        bit          exp_adm;
        logic [31:0] exp_desc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0;
        logic [31:0] d0;
        int base;

        vecs[0] = '{3, 32'd100,        1'b0, 0, 1'b1, 32'h8006_4000}; // admit, always ready
        vecs[1] = '{6, 32'd7,          1'b1, 0, 1'b0, 32'h0};         // drop on almost-full head
        vecs[2] = '{4, 32'd50,         1'b0, 1, 1'b1, 32'h8003_2000}; // late almost-full ignored
        vecs[3] = '{2, 32'd10,         1'b1, 1, 1'b0, 32'h0};         // next packet dropped
        vecs[4] = '{1, 32'h0010_0000,  1'b0, 0, 1'b1, 32'hFFFF_F000}; // clamp, single beat
        vecs[5] = '{1, 32'h0007_FFFF,  1'b0, 0, 1'b1, 32'hFFFF_F000}; // max rank exactly
        vecs[6] = '{2, 32'h0008_0000,  1'b0, 0, 1'b1, 32'hFFFF_F000}; // first clamping value
        vecs[7] = '{1, 32'd0,          1'b1, 1, 1'b0, 32'h0};         // single-beat drop
        vecs[8] = '{2, 32'd0,          1'b0, 0, 1'b1, 32'h8000_0000}; // rank zero

        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_trank  = '0;
        m_tready = 1'b1;
        af       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            a0 = adm_cnt;
            d0 = drp_cnt;
            last_head_p = '0;
            last_head_l = 1'b0;
            send_pkt(vecs[i].n, vecs[i].rank, vecs[i].af_head, vecs[i].af_rest, 0, 99);
            af = 1'b0;
            drain();
            chk($sformatf("vec%0d_adm_delta", i), adm_cnt - a0, {31'b0, vecs[i].exp_adm});
            chk($sformatf("vec%0d_drp_delta", i), drp_cnt - d0, {31'b0, !vecs[i].exp_adm});
            if (vecs[i].exp_adm) begin
                chk($sformatf("vec%0d_head_desc", i), last_head_p, vecs[i].exp_desc);
                chk($sformatf("vec%0d_head_last", i), last_head_l, vecs[i].n == 1);
            end
        end

        // Backpressure mid-packet: stall three cycles after the third output beat.
        base = out_beats;
        fork
            send_pkt(6, 32'd200, 1'b0, 0, 0, 99);
            begin
                for (int t = 0; t < 300; t++) begin
                    @(posedge clk);
                    if (out_beats >= base + 3) break;
                end
                #1;
                m_tready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stall_s_tready", s_tready, 1'b0);
                    chk("bp_stall_m_tvalid", m_tvalid, 1'b1);
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk("bp_beats_delivered", out_beats - base, 6);

        // Reset in the middle of a forwarded packet, then a fresh head.
        send_pkt(4, 32'd33, 1'b0, 0, 0, 2);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_adm_cnt", adm_cnt, 32'h0);
        @(posedge clk);
        #1;
        last_head_p = '0;
        send_pkt(2, 32'd20, 1'b0, 0, 0, 99);
        drain();
        chk("post_rst_head_desc", last_head_p, 32'h8001_4000);
        chk("post_rst_adm_one", adm_cnt, 32'h1);

        // Randomized traffic against the model.
        rnd_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 5),
                     ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(0, 600000)),
                     $urandom_range(1), 2, 20, 99);
        end
        af      = 1'b0;
        rnd_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
